// File: rtl/wb_defs_pkg.sv
// Shared codes for the writeback stage: write-data source selects, load types, M/W bubble.
package wb_defs;

    localparam logic [2:0] WD_SEL_ALU  = 3'd0;
    localparam logic [2:0] WD_SEL_LOAD = 3'd1;
    localparam logic [2:0] WD_SEL_LINK = 3'd2;
    localparam logic [2:0] WD_SEL_HI   = 3'd3;
    localparam logic [2:0] WD_SEL_LO   = 3'd4;
    localparam logic [2:0] WD_SEL_IMM  = 3'd5;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    typedef struct packed {
        logic       valid;
        logic       reg_we;
        logic [2:0] wd_sel;
    } mw_ctrl_t;

    localparam mw_ctrl_t MW_CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_ext.sv
// Combinational load extension: picks byte/half by address offset and sign/zero-extends.
// Zero latency; no flow control.
module load_ext
    import wb_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] ext
);

    logic [DATA_W-1:0] byte_shift;
    logic [DATA_W-1:0] half_shift;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    always_comb begin
        byte_shift = word >> {offset, 3'b000};
        half_shift = word >> {offset[1], 4'b0000};
        byte_v     = byte_shift[7:0];
        half_v     = half_shift[15:0];
        case (ld_type)
            LD_LB:   ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_v};
            LD_LH:   ext = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_LHU:  ext = {{(DATA_W-16){1'b0}}, half_v};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: M/W pipeline register plus GRF write-data select; W_* valid right after the capture edge.
// En=0 holds the register (stall); Flush loads a bubble. WB_LOAD_EXT_EN builds byte/half load extension.
module wb_stage
    import wb_defs::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_OFFSET = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              En,
    input  logic              Flush,
    input  logic [31:0]       M_PC,
    input  logic [DATA_W-1:0] M_ALU_Out,
    input  logic [DATA_W-1:0] M_Read_Data,
    input  logic [DATA_W-1:0] M_HI,
    input  logic [DATA_W-1:0] M_LO,
    input  logic [DATA_W-1:0] M_Imm,
    input  logic [2:0]        M_Wd_Sel,
    input  logic [2:0]        M_Ld_Type,
    input  logic              M_Reg_We,
    input  logic [ADDR_W-1:0] M_Reg_Addr,
    output logic              W_Valid,
    output logic [31:0]       W_PC,
    output logic              W_Reg_We,
    output logic [ADDR_W-1:0] W_Reg_Addr,
    output logic [DATA_W-1:0] W_Reg_Data
);

    mw_ctrl_t          ctrl_d, ctrl_q;
    logic [31:0]       pc_d, pc_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] alu_d, alu_q;
    logic [DATA_W-1:0] rd_d, rd_q;
    logic [DATA_W-1:0] hi_d, hi_q;
    logic [DATA_W-1:0] lo_d, lo_q;
    logic [DATA_W-1:0] imm_d, imm_q;
    logic [DATA_W-1:0] load_data;
    logic [31:0]       link_pc;
    logic [DATA_W-1:0] sel_data;
    logic              reg_we;

`ifdef WB_LOAD_EXT_EN
    logic [2:0] ld_type_d, ld_type_q;

    always_comb begin
        ld_type_d = ld_type_q;
        if (Flush)   ld_type_d = '0;
        else if (En) ld_type_d = M_Ld_Type;
    end

    always_ff @(posedge clk) begin
        if (reset) ld_type_q <= '0;
        else       ld_type_q <= ld_type_d;
    end

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .word    (rd_q),
        .offset  (alu_q[1:0]),
        .ld_type (ld_type_q),
        .ext     (load_data)
    );
`else
    logic unused_ld_type;
    assign unused_ld_type = ^M_Ld_Type;
    assign load_data      = rd_q;
`endif

    always_comb begin
        ctrl_d = ctrl_q;
        pc_d   = pc_q;
        addr_d = addr_q;
        alu_d  = alu_q;
        rd_d   = rd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        imm_d  = imm_q;
        if (Flush) begin
            ctrl_d = MW_CTRL_BUBBLE;
            pc_d   = '0;
            addr_d = '0;
            alu_d  = '0;
            rd_d   = '0;
            hi_d   = '0;
            lo_d   = '0;
            imm_d  = '0;
        end else if (En) begin
            ctrl_d = '{valid: 1'b1, reg_we: M_Reg_We, wd_sel: M_Wd_Sel};
            pc_d   = M_PC;
            addr_d = M_Reg_Addr;
            alu_d  = M_ALU_Out;
            rd_d   = M_Read_Data;
            hi_d   = M_HI;
            lo_d   = M_LO;
            imm_d  = M_Imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= MW_CTRL_BUBBLE;
            pc_q   <= '0;
            addr_q <= '0;
            alu_q  <= '0;
            rd_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            imm_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc_q   <= pc_d;
            addr_q <= addr_d;
            alu_q  <= alu_d;
            rd_q   <= rd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            imm_q  <= imm_d;
        end
    end

    // Link address wraps at 32 bits regardless of datapath width.
    assign link_pc = pc_q + 32'(LINK_OFFSET);

    always_comb begin
        case (ctrl_q.wd_sel)
            WD_SEL_ALU:  sel_data = alu_q;
            WD_SEL_LOAD: sel_data = load_data;
            WD_SEL_LINK: sel_data = DATA_W'(link_pc);
            WD_SEL_HI:   sel_data = hi_q;
            WD_SEL_LO:   sel_data = lo_q;
            WD_SEL_IMM:  sel_data = imm_q;
            default:     sel_data = '0;
        endcase
    end

    // Suppressed writes also zero the data so forwarding from W never leaks a stale value into $0 readers.
    assign reg_we     = ctrl_q.reg_we & ctrl_q.valid & (addr_q != '0);
    assign W_Valid    = ctrl_q.valid;
    assign W_PC       = pc_q;
    assign W_Reg_We   = reg_we;
    assign W_Reg_Addr = addr_q;
    assign W_Reg_Data = reg_we ? sel_data : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios then randomized traffic against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, En, Flush;
    logic [31:0] M_PC, M_ALU_Out, M_Read_Data, M_HI, M_LO, M_Imm;
    logic [2:0]  M_Wd_Sel, M_Ld_Type;
    logic        M_Reg_We;
    logic [4:0]  M_Reg_Addr;
    logic        W_Valid, W_Reg_We;
    logic [31:0] W_PC, W_Reg_Data;
    logic [4:0]  W_Reg_Addr;

    int checks = 0;
    int errors = 0;

    // Model of the instruction currently sitting in W.
    logic        m_valid, m_we;
    logic [31:0] m_pc, m_alu, m_rd, m_hi, m_lo, m_imm;
    logic [4:0]  m_addr;
    logic [2:0]  m_sel, m_ldt;

    logic [31:0] saved_data, saved_pc;
    logic [4:0]  saved_addr;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .ADDR_W(5), .LINK_OFFSET(8)) dut (
        .clk(clk), .reset(reset), .En(En), .Flush(Flush),
        .M_PC(M_PC), .M_ALU_Out(M_ALU_Out), .M_Read_Data(M_Read_Data),
        .M_HI(M_HI), .M_LO(M_LO), .M_Imm(M_Imm),
        .M_Wd_Sel(M_Wd_Sel), .M_Ld_Type(M_Ld_Type),
        .M_Reg_We(M_Reg_We), .M_Reg_Addr(M_Reg_Addr),
        .W_Valid(W_Valid), .W_PC(W_PC), .W_Reg_We(W_Reg_We),
        .W_Reg_Addr(W_Reg_Addr), .W_Reg_Data(W_Reg_Data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load();
        longint unsigned b, h;
`ifdef WB_LOAD_EXT_EN
        b = (longint'(m_rd) / (longint'(1) << (8 * (m_alu % 4)))) % 256;
        h = (longint'(m_rd) / (longint'(1) << (16 * ((m_alu % 4) / 2)))) % 65536;
        case (m_ldt)
            3'd1:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
            3'd2:    return 32'(b);
            3'd3:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
            3'd4:    return 32'(h);
            default: return m_rd;
        endcase
`else
        b = 0;
        h = b;
        return m_rd + 32'(h);
`endif
    endfunction

    function automatic logic exp_we();
        return m_we && m_valid && (m_addr != 5'd0);
    endfunction

    function automatic logic [31:0] exp_data();
        if (!exp_we()) return 32'd0;
        case (m_sel)
            3'd0:    return m_alu;
            3'd1:    return exp_load();
            3'd2:    return 32'((64'(m_pc) + 64'd8) % 64'h1_0000_0000);
            3'd3:    return m_hi;
            3'd4:    return m_lo;
            3'd5:    return m_imm;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_we = 0; m_pc = 0; m_alu = 0; m_rd = 0;
        m_hi = 0; m_lo = 0; m_imm = 0; m_addr = 0; m_sel = 0; m_ldt = 0;
    endtask

    // One clock: update the model from the inputs present at the edge, then compare everything.
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset || Flush) model_clear();
        else if (En) begin
            m_valid = 1; m_we = M_Reg_We; m_pc = M_PC; m_alu = M_ALU_Out;
            m_rd = M_Read_Data; m_hi = M_HI; m_lo = M_LO; m_imm = M_Imm;
            m_addr = M_Reg_Addr; m_sel = M_Wd_Sel; m_ldt = M_Ld_Type;
        end
        #1;
        chk({tag, ".valid"}, 32'(W_Valid), 32'(m_valid));
        chk({tag, ".pc"}, W_PC, m_pc);
        chk({tag, ".we"}, 32'(W_Reg_We), 32'(exp_we()));
        chk({tag, ".addr"}, 32'(W_Reg_Addr), 32'(m_addr));
        chk({tag, ".data"}, W_Reg_Data, exp_data());
    endtask

    task automatic rand_m();
        M_PC = $urandom; M_ALU_Out = $urandom; M_Read_Data = $urandom;
        M_HI = $urandom; M_LO = $urandom; M_Imm = $urandom;
        M_Wd_Sel = 3'($urandom_range(0, 7)); M_Ld_Type = 3'($urandom_range(0, 7));
        M_Reg_We = 1'($urandom); M_Reg_Addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    endtask

    task automatic set_m(input logic [2:0] sel, input logic [4:0] addr, input logic [31:0] alu);
        rand_m();
        M_Wd_Sel = sel; M_Reg_Addr = addr; M_ALU_Out = alu; M_Reg_We = 1'b1;
    endtask

    task automatic load_case(input string tag, input logic [2:0] ldt, input logic [31:0] alu,
                             input logic [31:0] want);
        set_m(3'd1, 5'd9, alu);
        M_Ld_Type = ldt; M_Read_Data = 32'h80FF7F01;
        tick(tag);
        chk({tag, ".const"}, W_Reg_Data, want);
    endtask

    initial begin
        model_clear();
        reset = 1; En = 1; Flush = 0;
        rand_m();

        // Reset held over two edges with random inputs.
        tick("rst0");
        rand_m();
        tick("rst1");
        chk("rst.valid0", 32'(W_Valid), 32'd0);
        chk("rst.data0", W_Reg_Data, 32'd0);
        chk("rst.pc0", W_PC, 32'd0);

        reset = 0;
        set_m(3'd0, 5'd3, 32'h1234);
        tick("first");
        chk("first.data", W_Reg_Data, 32'h1234);
        chk("first.we", 32'(W_Reg_We), 32'd1);
        chk("first.valid", 32'(W_Valid), 32'd1);

        // Link source including 32-bit wrap.
        set_m(3'd2, 5'd31, $urandom);
        M_PC = 32'h0000_3000;
        tick("link");
        chk("link.const", W_Reg_Data, 32'h0000_3008);
        set_m(3'd2, 5'd31, $urandom);
        M_PC = 32'hFFFF_FFFC;
        tick("linkwrap");
        chk("linkwrap.const", W_Reg_Data, 32'h0000_0004);

`ifdef WB_LOAD_EXT_EN
        load_case("lb", 3'd1, 32'h1003, 32'hFFFF_FF80);
        load_case("lbu", 3'd2, 32'h1002, 32'h0000_00FF);
        load_case("lh", 3'd3, 32'h1000, 32'h0000_7F01);
        load_case("lhu", 3'd4, 32'h1003, 32'h0000_80FF);
`else
        load_case("lbraw", 3'd1, 32'h1003, 32'h80FF_7F01);
        load_case("lhraw", 3'd3, 32'h1002, 32'h80FF_7F01);
`endif

        // Writes to $0 are suppressed and zeroed.
        set_m(3'd0, 5'd0, 32'hDEAD);
        tick("r0");
        chk("r0.we", 32'(W_Reg_We), 32'd0);
        chk("r0.data", W_Reg_Data, 32'd0);

        // Stall holds, then flush beats enable.
        set_m(3'd3, 5'd5, $urandom);
        M_HI = 32'hAA;
        tick("cap");
        saved_data = W_Reg_Data; saved_pc = W_PC; saved_addr = W_Reg_Addr;
        chk("cap.const", W_Reg_Data, 32'hAA);
        En = 0;
        for (int i = 0; i < 3; i++) begin
            rand_m();
            tick("stall");
            chk("stall.data", W_Reg_Data, saved_data);
            chk("stall.pc", W_PC, saved_pc);
            chk("stall.addr", 32'(W_Reg_Addr), 32'(saved_addr));
        end
        En = 1; Flush = 1;
        set_m(3'd0, 5'd6, 32'h55);
        tick("flush");
        chk("flush.valid", 32'(W_Valid), 32'd0);
        chk("flush.we", 32'(W_Reg_We), 32'd0);
        chk("flush.data", W_Reg_Data, 32'd0);
        Flush = 0;

        // Unused select codes give zero data but still write.
        set_m(3'd6, 5'd7, 32'h1357);
        tick("sel6");
        chk("sel6.we", 32'(W_Reg_We), 32'd1);
        chk("sel6.data", W_Reg_Data, 32'd0);

        // Reset during a stall still clears.
        En = 0; reset = 1;
        tick("rststall");
        chk("rststall.valid", 32'(W_Valid), 32'd0);
        reset = 0; En = 1;

        for (int i = 0; i < 400; i++) begin
            rand_m();
            reset = ($urandom_range(0, 39) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            En    = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
